// File: rtl/serial_addsub_digit.sv
// serial_addsub_digit: digit-serial two's-complement adder/subtractor, LS digit first, one cycle of registered latency
// Ports: clk, rst (async, active-high); in_valid/in_first/sub/a/b carry the input digit stream;
// out_valid/out_sum/out_last carry the result stream; carry_out/overflow are qualified by out_last;
// frame_err pulses for one cycle on a framing violation.
// Build option: define SERIAL_ADDSUB_DIGIT_SUB_EN to enable subtraction; without it the block is add-only and sub is ignored.
module serial_addsub_digit #(
  parameter int DIGIT_W = 1,
  parameter int DIGITS  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] out_sum,
  output logic               out_last,
  output logic               carry_out,
  output logic               overflow,
  output logic               frame_err
);
  localparam int CW = $clog2(DIGITS);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, mode_q, mode_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic carry_out_q, carry_out_d, overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic [DIGIT_W-1:0] out_sum_q, out_sum_d, sum;
  logic sub_en, start, accept, last, mode_eff, bx, cy, cy_msb;
`ifdef SERIAL_ADDSUB_DIGIT_SUB_EN
  assign sub_en = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_en = 1'b0;
`endif
  assign start    = in_valid & in_first;
  assign accept   = start | (in_valid & (state_q == ACTIVE));
  // in_first on the final position is a restart, so it never closes the old word
  assign last     = accept & ~in_first & (cnt_q == CW'(DIGITS - 1));
  assign mode_eff = start ? sub_en : mode_q;
  // Ripple of full adders; cy_msb keeps the carry into the MS bit for overflow
  always_comb begin
    cy = start ? sub_en : carry_q;
    cy_msb = 1'b0;
    bx = 1'b0;
    sum = '0;
    for (int i = 0; i < DIGIT_W; i++) begin
      bx = b[i] ^ mode_eff;
      sum[i] = a[i] ^ bx ^ cy;
      cy_msb = cy;
      cy = (a[i] & bx) | (cy & (a[i] ^ bx));
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    mode_d = mode_q;
    if (start) begin
      state_d = ACTIVE;
      cnt_d = CW'(1);
      mode_d = sub_en;
      carry_d = cy;
    end else if (accept) begin
      state_d = last ? IDLE : ACTIVE;
      cnt_d = last ? '0 : cnt_q + CW'(1);
      carry_d = cy;
    end
  end
  always_comb begin
    out_valid_d = accept;
    out_sum_d   = accept ? sum : '0;
    out_last_d  = last;
    carry_out_d = last & cy;
    overflow_d  = last & (cy ^ cy_msb);
    frame_err_d = in_valid & (in_first ? (state_q == ACTIVE) : (state_q == IDLE));
  end
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;
endmodule

// File: doc/serial_addsub_digit.md
SERIAL_ADDSUB_DIGIT -- requirements
Module: serial_addsub_digit

Interface
REQ-001 SHALL have parameter DIGIT_W, default 1, bits of each operand consumed per cycle (legal range 1..16).
REQ-002 SHALL have parameter DIGITS, default 8, digits per word; word width is DIGIT_W*DIGITS (legal range DIGITS >= 2).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  a/b/in_first/sub qualify this cycle.
REQ-006 SHALL have port in_first  input  1  current digit is the least-significant digit of a new word.
REQ-007 SHALL have port sub  input  1  operation select, sampled only on the first digit (0 = a+b, 1 = a-b).
REQ-008 SHALL have port a  input  DIGIT_W  operand A digit, LS digit first.
REQ-009 SHALL have port b  input  DIGIT_W  operand B digit, LS digit first.
REQ-010 SHALL have port out_valid  output  1  out_sum holds a result digit.
REQ-011 SHALL have port out_sum  output  DIGIT_W  result digit.
REQ-012 SHALL have port out_last  output  1  out_sum is the MS digit of the word.
REQ-013 SHALL have port carry_out  output  1  final carry of the word, valid only with out_last (for sub, 1 = no borrow).
REQ-014 SHALL have port overflow  output  1  two's-complement signed overflow, valid only with out_last.
REQ-015 SHALL have port frame_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (no word in progress) and ACTIVE (word in progress; digit counter 1..DIGITS-1).
REQ-017 SHALL start a word on in_valid&in_first in either state: latch sub into the mode register, use carry-in = sub, set the counter to 1 and enter ACTIVE.
REQ-018 SHALL form each digit as a ripple of 1-bit full adders built only from XOR/AND/OR/NOT: operand b is XORed with the latched mode (or with sub on the first digit), and the internal carry register feeds bit 0.
REQ-019 SHALL, on each accepted digit, update the carry register with the carry out of bit DIGIT_W-1 and increment the counter.
REQ-020 SHALL register every output, giving exactly one cycle of latency from the accepted digit to out_valid/out_sum.
REQ-021 SHALL, when in_valid is low, hold the FSM, counter, carry and mode, and drive out_valid, out_last and frame_err low (stall allowed at any point).
REQ-022 SHALL, on the digit at counter DIGITS-1, assert out_last with out_valid, drive carry_out = final carry and overflow = carry into MS bit XOR carry out of MS bit, then return to IDLE.
REQ-023 SHALL hold carry_out and overflow at 0 when out_last is 0.
REQ-024 SHALL, on in_valid&in_first while ACTIVE, abandon the current word (no out_last is emitted for it), pulse frame_err, and start the new word per REQ-017 with its digit output normally.
REQ-025 SHALL, on in_valid&~in_first in IDLE, discard the digit (out_valid stays 0) and pulse frame_err.
REQ-026 SHALL treat in_first on the final digit position as a restart per REQ-024.

Reset
REQ-027 SHALL, while rst is high, force IDLE, counter=0, carry=0, mode=0, and all outputs (out_valid, out_sum, out_last, carry_out, overflow, frame_err) to 0, asynchronously.
REQ-028 SHALL, after reset is asserted mid-word, discard that word; the first accepted digit after reset must carry in_first.

Configuration
REQ-029 SHALL support macro SERIAL_ADDSUB_DIGIT_SUB_EN: when defined, sub behaves per REQ-007/017/018.
REQ-030 SHALL, when SERIAL_ADDSUB_DIGIT_SUB_EN is undefined, ignore the sub port, hold the mode at 0 and carry-in at 0 (add only), and keep the port list unchanged.

Verification (SUB_EN defined unless noted)
REQ-031 SHALL cover DIGIT_W=1, DIGITS=8, a=0x5A, b=0x3C, sub=0 streamed LS-first back-to-back -> out_sum bits form 0x96 over 8 cycles at 1-cycle latency, out_last on the 8th, carry_out=0, overflow=1.
REQ-032 SHALL cover DIGIT_W=1, DIGITS=8, 0x10-0x20 with sub=1 -> 0xF0, carry_out=0 (borrow), overflow=0; the same stimulus with the macro undefined -> 0x30 (add).
REQ-033 SHALL cover DIGIT_W=4, DIGITS=2, 0xFF+0x01 with an idle in_valid=0 gap of 3 cycles between digits -> digits 0x0,0x0, carry_out=1, overflow=0, and out_valid low during the gap.
REQ-034 SHALL cover in_first reasserted at digit 3 of an 8-digit word -> frame_err pulses once, no out_last for the old word, and the new word completes correctly after 8 more digits.
REQ-035 SHALL cover rst asserted for 1 cycle at digit 4 of a word -> all outputs 0 immediately (asynchronous); a following digit without in_first -> frame_err=1, out_valid=0.
